serial_byte_collector: RTL and testbench

Serial-to-parallel front end for the 8-bit flip-flop register stage. Samples one serial bit per strobe while a frame is open and assembles WIDTH bits in a private shift register. On completion it publishes the byte on `dout` with a one-cycle `dout_valid` pulse, ready to drive the register's parallel `A[0:7]` input. Partial bytes are never visible on `dout`. A frame that closes mid-byte is discarded and flagged.

---
 rtl/serial_byte_collector_pkg.sv | 17 +
 rtl/serial_byte_collector_dff_en.sv | 18 +
 rtl/serial_byte_collector.sv | 122 ++++++++++++
 tb/tb_serial_byte_collector.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_byte_collector_pkg.sv
// Shared types and constants for the serial byte collector.
// State encoding, default byte width and counter width helper.
package sbc_pkg;

    localparam int SBC_WIDTH = 8;

    typedef enum logic {
        SBC_IDLE  = 1'b0,
        SBC_SHIFT = 1'b1
    } sbc_state_e;

    // ceil(log2(w)), never below one bit
    function automatic int sbc_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_byte_collector_dff_en.sv
// Single-bit D flip-flop with synchronous active-high reset
// and load enable.
module dff_en (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/serial_byte_collector.sv
// Serial-to-parallel byte collector: shifts in framed bits and
// publishes only completed bytes on dout with a valid pulse.
module serial_byte_collector
    import sbc_pkg::*;
#(
    parameter int WIDTH     = SBC_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = sbc_cnt_w(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sin,
    input  logic            sin_en,
    input  logic            frame,
    output logic [0:WIDTH-1] dout,
    output logic            dout_valid,
    output logic            busy,
    output logic            frame_err,
    output logic [CW-1:0]   bit_cnt
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sbc_state_e state, state_n;

    logic [CW-1:0]    cnt_n;
    logic             acc;
    logic             sh_en;
    logic             sh_clr;
    logic             done;
    logic             err;
    logic [0:WIDTH-1] sh_q;
    logic [0:WIDTH-1] sh_nxt;
    logic [0:WIDTH-1] sh_d;

    assign acc = frame & sin_en;

    // Index 0 is the MSB; MSB_FIRST pushes bits in from the right
    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_nxt = {sh_q[1:WIDTH-1], sin};
        end else begin : g_lsb
            assign sh_nxt = {sin, sh_q[0:WIDTH-2]};
        end
    endgenerate

    assign sh_d = sh_clr ? '0 : sh_nxt;

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_en   = 1'b0;
        sh_clr  = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state)
            SBC_IDLE: begin
                if (acc) begin
                    sh_en   = 1'b1;
                    cnt_n   = CW'(1);
                    state_n = SBC_SHIFT;
                end
            end
            SBC_SHIFT: begin
                if (!frame) begin
                    state_n = SBC_IDLE;
                    if (bit_cnt != '0) begin
                        err    = 1'b1;
                        sh_clr = 1'b1;
                        cnt_n  = '0;
                    end
                end else if (sin_en) begin
                    sh_en = 1'b1;
                    if (bit_cnt == LAST) begin
                        done  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n = bit_cnt + CW'(1);
                    end
                end
            end
            default: state_n = SBC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SBC_IDLE;
            bit_cnt    <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            dout_valid <= done;
            frame_err  <= err;
            busy       <= (state_n == SBC_SHIFT) && (cnt_n != '0);
        end
    end

    // dout takes the word including the bit accepted this edge
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            dff_en u_sh (
                .clk (clk),
                .rst (rst),
                .en  (sh_en | sh_clr),
                .d   (sh_d[i]),
                .q   (sh_q[i])
            );
            dff_en u_do (
                .clk (clk),
                .rst (rst),
                .en  (done),
                .d   (sh_nxt[i]),
                .q   (dout[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_serial_byte_collector.sv
// Table-driven bench for serial_byte_collector plus hand-written
// sequences for back-to-back bytes and reset mid-byte.
module tb_serial_byte_collector;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_en;
    logic       frame;
    logic [0:7] dout;
    logic       dout_valid;
    logic       busy;
    logic       frame_err;
    logic [2:0] bit_cnt;

    int total;
    int bad;
    int both_hi;

    typedef struct {
        logic       r;
        logic       f;
        logic       e;
        logic       s;
        logic [7:0] x_dout;
        logic       x_dv;
        logic       x_fe;
        logic       x_busy;
        logic [2:0] x_cnt;
    } vec_t;

    vec_t vec[$];

    serial_byte_collector #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .frame      (frame),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .bit_cnt    (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (dout_valid && frame_err)
            both_hi++;

    task automatic add(input logic r, f, e, s,
                       input logic [7:0] xd,
                       input logic xv, xf, xb,
                       input logic [2:0] xc);
        vec_t v;
        v.r = r; v.f = f; v.e = e; v.s = s;
        v.x_dout = xd; v.x_dv = xv; v.x_fe = xf;
        v.x_busy = xb; v.x_cnt = xc;
        vec.push_back(v);
    endtask

    task automatic drive(input logic r, f, e, s);
        rst = r; frame = f; sin_en = e; sin = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] c3;
        logic [7:0] w2;
        logic [15:0] pair;
        int         npulse;
        int         p0;
        int         p1;
        int         nerr;
        logic [7:0] v0;
        logic [7:0] v1;
        logic [13:0] got;
        logic [13:0] exp;

        total = 0; bad = 0; both_hi = 0;
        rst = 1'b1; frame = 1'b0; sin_en = 1'b0; sin = 1'b0;
        a5 = 8'hA5;
        c3 = 8'h3C;

        // reset with noisy inputs
        add(1, 1, 1, 1, 8'h00, 0, 0, 0, 3'd0);
        add(1, 1, 1, 0, 8'h00, 0, 0, 0, 3'd0);
        // strobe without frame is ignored
        add(0, 0, 1, 1, 8'h00, 0, 0, 0, 3'd0);
        // 0xA5, continuous strobes
        for (int k = 0; k < 8; k++)
            add(0, 1, 1, a5[7-k],
                (k == 7) ? 8'hA5 : 8'h00,
                k == 7, 0, k != 7, 3'((k + 1) % 8));
        add(0, 1, 0, 0, 8'hA5, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 8'hA5, 0, 0, 0, 3'd0);
        // abort after 5 bits; last strobe coincides with frame drop
        for (int k = 0; k < 5; k++)
            add(0, 1, 1, a5[7-k], 8'hA5, 0, 0, 1, 3'(k + 1));
        add(0, 0, 1, 1, 8'hA5, 0, 1, 0, 3'd0);
        add(0, 0, 1, 0, 8'hA5, 0, 0, 0, 3'd0);
        // 0x3C with a strobe every third cycle
        for (int k = 0; k < 8; k++) begin
            add(0, 1, 1, c3[7-k],
                (k == 7) ? 8'h3C : 8'hA5,
                k == 7, 0, k != 7, 3'((k + 1) % 8));
            for (int g = 0; g < 2; g++)
                add(0, 1, 0, 0,
                    (k == 7) ? 8'h3C : 8'hA5,
                    0, 0, k != 7, 3'((k + 1) % 8));
        end
        add(0, 0, 0, 0, 8'h3C, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 8'h3C, 0, 0, 0, 3'd0);

        for (int i = 0; i < vec.size(); i++) begin
            drive(vec[i].r, vec[i].f, vec[i].e, vec[i].s);
            got = {dout, dout_valid, frame_err, busy, bit_cnt};
            exp = {vec[i].x_dout, vec[i].x_dv, vec[i].x_fe,
                   vec[i].x_busy, vec[i].x_cnt};
            chk($sformatf("vec%0d{dout,dv,fe,busy,cnt}", i),
                32'(got), 32'(exp));
        end

        // back-to-back 0xA5 then 0x5A inside one frame
        pair = 16'hA55A;
        npulse = 0; p0 = -1; p1 = -1; nerr = 0;
        v0 = 8'h00; v1 = 8'h00;
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 1, pair[15-k]);
            if (frame_err) nerr++;
            if (dout_valid) begin
                if (npulse == 0) begin p0 = k; v0 = dout; end
                else begin p1 = k; v1 = dout; end
                npulse++;
            end
        end
        drive(0, 1, 0, 0);
        if (dout_valid) npulse++;
        chk("b2b_pulses", 32'(npulse), 32'd2);
        chk("b2b_first_byte", 32'(v0), 32'hA5);
        chk("b2b_second_byte", 32'(v1), 32'h5A);
        chk("b2b_spacing", 32'(p1 - p0), 32'd8);
        chk("b2b_dout_hold", 32'(dout), 32'h5A);
        drive(0, 0, 0, 0);
        if (frame_err) nerr++;
        chk("b2b_no_err", 32'(nerr), 32'd0);

        // reset after 4 bits, then send 0xFF
        nerr = 0; npulse = 0;
        for (int k = 0; k < 4; k++)
            drive(0, 1, 1, 1'b1);
        chk("mid_cnt", 32'(bit_cnt), 32'd4);
        drive(1, 1, 1, 1'b1);
        if (frame_err) nerr++;
        chk("mid_rst_dout", 32'(dout), 32'h00);
        chk("mid_rst_cnt", 32'(bit_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 1, 1'b1);
            if (frame_err) nerr++;
            if (dout_valid) npulse++;
        end
        chk("mid_ff_dout", 32'(dout), 32'hFF);
        drive(0, 0, 0, 0);
        if (frame_err) nerr++;
        if (dout_valid) npulse++;
        chk("mid_ff_pulses", 32'(npulse), 32'd1);
        chk("mid_no_err", 32'(nerr), 32'd0);

        // one idle cycle in gapped MSB-first check of count and output hold
        w2 = dout;
        drive(0, 0, 1, 1'b0);
        chk("idle_hold", 32'(dout), 32'(w2));
        chk("dv_fe_exclusive", 32'(both_hi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
